// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Purpose:
//   Shares one external asynchronous SRAM between the SNES cartridge bus
//   (read-only, real-time) and the AVR (upload/readback, read/write). Each
//   access runs through IDLE -> GRANT -> ACCESS -> RECOVER. ACCESS lasts
//   RD_WAIT or WR_WAIT clocks and RECOVER is a single dead cycle. The
//   granted requester sees a one-cycle ack in RECOVER.
//
// Configuration macro:
//   SRAM_ARB_ROUND_ROBIN_EN - when defined, a SNES access that completes
//   while the AVR is waiting hands the next arbitration to the AVR, so the
//   AVR never waits longer than one SNES access. When undefined, the SNES
//   always has priority and the AVR can starve.
//
// Ports:
//   clk, reset_n         system clock (rising edge), async active-low reset
//   snes_req/addr        SNES read request (level) and address
//   snes_rdata/ack       SNES read data (held) and one-cycle completion pulse
//   avr_req/wr/addr      AVR request (level), write flag, address
//   avr_wdata            AVR write data
//   avr_rdata/ack        AVR read data (held) and one-cycle completion pulse
//   sram_addr            SRAM address (changes only on entry to GRANT)
//   sram_dout/dout_en    SRAM write data and tristate enable
//   sram_din             SRAM read data from the pins
//   sram_ce_n/oe_n/we_n  SRAM strobes, active-low
//   owner_avr            1 while the current/last grant belongs to the AVR
// -----------------------------------------------------------------------------
module sram_arbiter #(
    parameter int ADDR_W  = 21,
    parameter int DATA_W  = 8,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              snes_req,
    input  logic [ADDR_W-1:0] snes_addr,
    output logic [DATA_W-1:0] snes_rdata,
    output logic              snes_ack,
    input  logic              avr_req,
    input  logic              avr_wr,
    input  logic [ADDR_W-1:0] avr_addr,
    input  logic [DATA_W-1:0] avr_wdata,
    output logic [DATA_W-1:0] avr_rdata,
    output logic              avr_ack,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dout,
    output logic              sram_dout_en,
    input  logic [DATA_W-1:0] sram_din,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              owner_avr
);

    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        ACCESS  = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic               r_ownerAvr;
    logic               r_isWrite;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_dout;
    logic [DATA_W-1:0]  r_snesRdata;
    logic [DATA_W-1:0]  r_avrRdata;
    logic [CNT_W-1:0]   r_waitCnt;
    logic [CNT_W-1:0]   w_waitLast;
    logic               w_grantAny;
    logic               w_grantAvr;
    logic               w_accessDone;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic               r_avrTurn;
`endif

    // Arbitration. SNES wins by default; with round robin the AVR wins once
    // after a SNES access that completed while the AVR was waiting.
    always_comb begin
        w_grantAny = snes_req | avr_req;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        w_grantAvr = avr_req & (~snes_req | r_avrTurn);
`else
        w_grantAvr = avr_req & ~snes_req;
`endif
    end

    // The access window length depends on the direction latched at grant.
    always_comb begin
        w_waitLast   = r_isWrite ? CNT_W'(WR_WAIT - 1) : CNT_W'(RD_WAIT - 1);
        w_accessDone = (r_state == ACCESS) && (r_waitCnt == w_waitLast);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and strobe decode. Strobes are decoded from the state
    // register so an asynchronous reset releases the SRAM immediately.
    always_comb begin
        w_nextState  = r_state;
        sram_ce_n    = 1'b1;
        sram_oe_n    = 1'b1;
        sram_we_n    = 1'b1;
        sram_dout_en = 1'b0;
        snes_ack     = 1'b0;
        avr_ack      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_grantAny) begin
                    w_nextState = GRANT;
                end
            end
            GRANT: begin
                sram_ce_n    = 1'b0;
                sram_dout_en = r_isWrite;
                w_nextState  = ACCESS;
            end
            ACCESS: begin
                sram_ce_n    = 1'b0;
                sram_oe_n    = r_isWrite;
                sram_we_n    = ~r_isWrite;
                sram_dout_en = r_isWrite;
                if (w_accessDone) begin
                    w_nextState = RECOVER;
                end
            end
            RECOVER: begin
                // Write data is held one extra cycle after we_n rises.
                sram_dout_en = r_isWrite;
                snes_ack     = ~r_ownerAvr;
                avr_ack      = r_ownerAvr;
                w_nextState  = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Grant latch. Address, direction and write data are captured only on
    // the IDLE->GRANT edge so they are stable across the strobe window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ownerAvr <= 1'b0;
            r_isWrite  <= 1'b0;
            r_addr     <= '0;
            r_dout     <= '0;
        end else if (r_state == IDLE && w_grantAny) begin
            r_ownerAvr <= w_grantAvr;
            r_isWrite  <= w_grantAvr & avr_wr;
            r_addr     <= w_grantAvr ? avr_addr : snes_addr;
            if (w_grantAvr && avr_wr) begin
                r_dout <= avr_wdata;
            end
        end
    end

    // Wait-state counter, cleared in GRANT and stepped through ACCESS.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_waitCnt <= '0;
        end else if (r_state == GRANT) begin
            r_waitCnt <= '0;
        end else if (r_state == ACCESS) begin
            r_waitCnt <= r_waitCnt + CNT_W'(1);
        end
    end

    // Read data is captured on the last ACCESS edge while oe_n is still low,
    // and each requester's copy is held until its next read completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_snesRdata <= '0;
            r_avrRdata  <= '0;
        end else if (w_accessDone && !r_isWrite) begin
            if (r_ownerAvr) begin
                r_avrRdata <= sram_din;
            end else begin
                r_snesRdata <= sram_din;
            end
        end
    end

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // AVR turn flag: set when a SNES access finishes with the AVR waiting,
    // cleared as soon as the AVR is granted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_avrTurn <= 1'b0;
        end else if (r_state == RECOVER && !r_ownerAvr && avr_req) begin
            r_avrTurn <= 1'b1;
        end else if (r_state == IDLE && w_grantAvr) begin
            r_avrTurn <= 1'b0;
        end
    end
`endif

    assign sram_addr  = r_addr;
    assign sram_dout  = r_dout;
    assign snes_rdata = r_snesRdata;
    assign avr_rdata  = r_avrRdata;
    assign owner_avr  = r_ownerAvr;

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//
// Directed bench for sram_arbiter with default parameters (21-bit address,
// 8-bit data, RD_WAIT = WR_WAIT = 2). A small SRAM model answers reads while
// oe_n is low and stores writes while we_n is low. Cycle 0 is the IDLE cycle
// in which a request is first presented; cycle n is sampled 1 ns after the
// n-th following rising edge.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

    logic        clk;
    logic        reset_n;
    logic        snes_req;
    logic [20:0] snes_addr;
    logic [7:0]  snes_rdata;
    logic        snes_ack;
    logic        avr_req;
    logic        avr_wr;
    logic [20:0] avr_addr;
    logic [7:0]  avr_wdata;
    logic [7:0]  avr_rdata;
    logic        avr_ack;
    logic [20:0] sram_addr;
    logic [7:0]  sram_dout;
    logic        sram_dout_en;
    logic [7:0]  sram_din;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        owner_avr;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:1023];

    sram_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .snes_req     (snes_req),
        .snes_addr    (snes_addr),
        .snes_rdata   (snes_rdata),
        .snes_ack     (snes_ack),
        .avr_req      (avr_req),
        .avr_wr       (avr_wr),
        .avr_addr     (avr_addr),
        .avr_wdata    (avr_wdata),
        .avr_rdata    (avr_rdata),
        .avr_ack      (avr_ack),
        .sram_addr    (sram_addr),
        .sram_dout    (sram_dout),
        .sram_dout_en (sram_dout_en),
        .sram_din     (sram_din),
        .sram_ce_n    (sram_ce_n),
        .sram_oe_n    (sram_oe_n),
        .sram_we_n    (sram_we_n),
        .owner_avr    (owner_avr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: output data while oe_n is low, store on a clock edge that
    // sees we_n, ce_n low and the bus driven.
    assign sram_din = (!sram_oe_n && !sram_ce_n) ? mem[sram_addr[9:0]] : 8'h00;

    always @(posedge clk) begin
        if (!sram_we_n && !sram_ce_n && sram_dout_en) begin
            mem[sram_addr[9:0]] <= sram_dout;
        end
    end

    // Step to the sample point of the next cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en} !== 4'b1110) begin
            errors++;
            $display("[TB] FAIL reset_strobes got %b want 1110", {sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en});
        end
        checks++;
        if ({sram_addr, sram_dout, snes_rdata, avr_rdata} !== 45'd0) begin
            errors++;
            $display("[TB] FAIL reset_data addr=%h dout=%h srd=%h ard=%h want all 0", sram_addr, sram_dout, snes_rdata, avr_rdata);
        end
        checks++;
        if ({snes_ack, avr_ack, owner_avr} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_ack_owner got %b want 000", {snes_ack, avr_ack, owner_avr});
        end
        reset_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_avr_write();
        logic [3:0] expStrobe [5];
        int weLow = 0;
        int ackCycle = -1;
        expStrobe = '{4'b0111, 4'b0101, 4'b0101, 4'b1111, 4'b1110};
        avr_wr    = 1'b1;
        avr_addr  = 21'h012345;
        avr_wdata = 8'hA5;
        avr_req   = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (avr_ack && ackCycle < 0) begin
                ackCycle = c;
                avr_req  = 1'b0;
            end
            if (!sram_we_n) weLow++;
            checks++;
            if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en} !== expStrobe[c-1]) begin
                errors++;
                $display("[TB] FAIL wr_strobes cycle %0d got %b want %b", c, {sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en}, expStrobe[c-1]);
            end
            if (c == 1) begin
                checks++;
                if (sram_addr !== 21'h012345 || sram_dout !== 8'hA5) begin
                    errors++;
                    $display("[TB] FAIL wr_addr_data got %h/%h want 012345/a5", sram_addr, sram_dout);
                end
            end
        end
        checks++;
        if (weLow !== 2) begin
            errors++;
            $display("[TB] FAIL wr_we_width got %0d want 2", weLow);
        end
        checks++;
        if (ackCycle !== 4) begin
            errors++;
            $display("[TB] FAIL wr_ack_cycle got %0d want 4", ackCycle);
        end
    endtask

    task automatic test_avr_read();
        logic [3:0] expStrobe [5];
        int oeLow = 0;
        int ackCycle = -1;
        expStrobe = '{4'b0110, 4'b0010, 4'b0010, 4'b1110, 4'b1110};
        avr_wr   = 1'b0;
        avr_addr = 21'h012345;
        avr_req  = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (avr_ack && ackCycle < 0) begin
                ackCycle = c;
                avr_req  = 1'b0;
                checks++;
                if (avr_rdata !== 8'hA5) begin
                    errors++;
                    $display("[TB] FAIL rd_data got %h want a5", avr_rdata);
                end
            end
            if (!sram_oe_n) oeLow++;
            checks++;
            if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en} !== expStrobe[c-1]) begin
                errors++;
                $display("[TB] FAIL rd_strobes cycle %0d got %b want %b", c, {sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en}, expStrobe[c-1]);
            end
        end
        checks++;
        if (oeLow !== 2 || ackCycle !== 4) begin
            errors++;
            $display("[TB] FAIL rd_timing oe_low=%0d ack=%0d want 2/4", oeLow, ackCycle);
        end
    endtask

    task automatic test_contention();
        int sAck = -1;
        int aAck = -1;
        snes_addr = 21'h000010;
        avr_wr    = 1'b1;
        avr_addr  = 21'h000020;
        avr_wdata = 8'h5C;
        snes_req  = 1'b1;
        avr_req   = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (snes_ack && sAck < 0) begin
                sAck     = c;
                snes_req = 1'b0;
                checks++;
                if (snes_rdata !== 8'h3C) begin
                    errors++;
                    $display("[TB] FAIL cont_snes_data got %h want 3c", snes_rdata);
                end
            end
            if (avr_ack && aAck < 0) begin
                aAck    = c;
                avr_req = 1'b0;
            end
            if (c == 1) begin
                checks++;
                if (owner_avr !== 1'b0 || sram_addr !== 21'h000010) begin
                    errors++;
                    $display("[TB] FAIL cont_first_grant owner=%b addr=%h want 0/000010", owner_avr, sram_addr);
                end
            end
            if (c == 6) begin
                checks++;
                if (owner_avr !== 1'b1 || sram_addr !== 21'h000020 || sram_dout_en !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL cont_avr_grant owner=%b addr=%h en=%b want 1/000020/1", owner_avr, sram_addr, sram_dout_en);
                end
            end
        end
        checks++;
        if (sAck !== 4 || aAck !== 9) begin
            errors++;
            $display("[TB] FAIL cont_ack_cycles snes=%0d avr=%0d want 4/9", sAck, aAck);
        end
        checks++;
        if (mem[10'h020] !== 8'h5C) begin
            errors++;
            $display("[TB] FAIL cont_write_stored got %h want 5c", mem[10'h020]);
        end
    endtask

    task automatic test_back_to_back();
        int ack1 = -1;
        int ack2 = -1;
        snes_addr = 21'h000100;
        snes_req  = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (snes_ack) begin
                checks++;
                if (sram_ce_n !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL b2b_recover_ce cycle %0d got %b want 1", c, sram_ce_n);
                end
                if (ack1 < 0) begin
                    ack1 = c;
                    checks++;
                    if (snes_rdata !== 8'h11) begin
                        errors++;
                        $display("[TB] FAIL b2b_data1 got %h want 11", snes_rdata);
                    end
                    snes_addr = 21'h000101;
                end else if (ack2 < 0) begin
                    ack2 = c;
                    checks++;
                    if (snes_rdata !== 8'h22) begin
                        errors++;
                        $display("[TB] FAIL b2b_data2 got %h want 22", snes_rdata);
                    end
                    snes_req = 1'b0;
                end
            end
        end
        checks++;
        if (ack1 !== 4 || ack2 !== 9) begin
            errors++;
            $display("[TB] FAIL b2b_ack_cycles got %0d/%0d want 4/9", ack1, ack2);
        end
    endtask

    task automatic test_starvation();
        int sCount = 0;
        int aCount = 0;
        int firstAvr = -1;
        snes_addr = 21'h000100;
        avr_wr    = 1'b0;
        avr_addr  = 21'h000020;
        snes_req  = 1'b1;
        avr_req   = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (snes_ack) sCount++;
            if (avr_ack) begin
                aCount++;
                if (firstAvr < 0) firstAvr = c;
            end
        end
        snes_req = 1'b0;
        avr_req  = 1'b0;
        for (int c = 0; c < 6; c++) tick();
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        checks++;
        if (sCount !== 3 || aCount !== 2 || firstAvr !== 9) begin
            errors++;
            $display("[TB] FAIL rr_alternate snes=%0d avr=%0d first=%0d want 3/2/9", sCount, aCount, firstAvr);
        end
`else
        checks++;
        if (sCount !== 5 || aCount !== 0) begin
            errors++;
            $display("[TB] FAIL fixed_priority snes=%0d avr=%0d want 5/0", sCount, aCount);
        end
`endif
    endtask

    task automatic test_reset_mid_access();
        int badAck = 0;
        int ackCycle = -1;
        avr_wr    = 1'b1;
        avr_addr  = 21'h000030;
        avr_wdata = 8'h77;
        avr_req   = 1'b1;
        tick();
        tick();
        checks++;
        if (sram_we_n !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_setup we_n got %b want 0", sram_we_n);
        end
        reset_n = 1'b0;
        avr_req = 1'b0;
        #1;
        checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en, avr_ack} !== 5'b11100) begin
            errors++;
            $display("[TB] FAIL mid_reset_release got %b want 11100", {sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en, avr_ack});
        end
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (avr_ack || snes_ack || !sram_ce_n) badAck++;
        end
        checks++;
        if (badAck !== 0) begin
            errors++;
            $display("[TB] FAIL mid_reset_quiet got %0d active cycles want 0", badAck);
        end
        checks++;
        if (snes_rdata !== 8'h00) begin
            errors++;
            $display("[TB] FAIL mid_reset_rdata got %h want 00", snes_rdata);
        end
        snes_addr = 21'h000010;
        snes_req  = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (snes_ack && ackCycle < 0) begin
                ackCycle = c;
                snes_req = 1'b0;
            end
        end
        checks++;
        if (ackCycle !== 4 || snes_rdata !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL mid_reset_idle ack=%0d data=%h want 4/3c", ackCycle, snes_rdata);
        end
    endtask

    // Watchdog so a wedged design still ends the run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset_n   = 1'b0;
        snes_req  = 1'b0;
        snes_addr = '0;
        avr_req   = 1'b0;
        avr_wr    = 1'b0;
        avr_addr  = '0;
        avr_wdata = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h010] = 8'h3C;
        mem[10'h100] = 8'h11;
        mem[10'h101] = 8'h22;

        test_reset();
        test_avr_write();
        tick();
        test_avr_read();
        tick();
        test_contention();
        tick();
        test_back_to_back();
        tick();
        test_starvation();
        test_reset_mid_access();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external SRAM between two requesters: the SNES cartridge bus (read-only, real-time) and the AVR (upload/readback, read/write).
- Owns SRAM address, data direction and the oe_n/we_n/ce_n strobes.
- Sequences each access with programmable wait states and a recovery cycle.
- Sits between the AVR shift-register/bus logic and the SRAM pins, replacing direct strobe pass-through.

Parameters:
- ADDR_W, 21, SRAM address width.
- DATA_W, 8, SRAM data width.
- RD_WAIT, 2, clk cycles oe_n/ce_n held low per read (min 1).
- WR_WAIT, 2, clk cycles we_n held low per write (min 1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- snes_req  input  1  SNES read request; level, held until snes_ack.
- snes_addr  input  ADDR_W  SNES read address, stable while snes_req.
- snes_rdata  output  DATA_W  read data, valid in the cycle snes_ack=1 and held until next SNES read completes.
- snes_ack  output  1  one-cycle completion pulse.
- avr_req  input  1  AVR request; level, held until avr_ack.
- avr_wr  input  1  1=write, 0=read; stable while avr_req.
- avr_addr  input  ADDR_W  AVR address.
- avr_wdata  input  DATA_W  AVR write data.
- avr_rdata  output  DATA_W  read data, valid with avr_ack and held until the next AVR read completes.
- avr_ack  output  1  one-cycle completion pulse.
- sram_addr  output  ADDR_W  SRAM address.
- sram_dout  output  DATA_W  data to SRAM.
- sram_dout_en  output  1  1 = drive sram_data bus (tristate enable).
- sram_din  input  DATA_W  data from SRAM pins.
- sram_ce_n, sram_oe_n, sram_we_n  output  1 each  SRAM strobes, active-low.
- owner_avr  output  1  1 while the current/last grant belongs to AVR (debug).

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE.
  - Strobes all 1; sram_dout_en=0.
  - sram_addr, sram_dout, snes_rdata, avr_rdata all 0.
  - Acks 0; owner_avr=0; wait counter 0.
- States:
  - IDLE → GRANT on any req.
  - GRANT (1 cycle) → ACCESS.
  - ACCESS (RD_WAIT or WR_WAIT cycles) → RECOVER.
  - RECOVER (1 cycle) → IDLE.
- IDLE arbitration: if snes_req, grant SNES; else if avr_req, grant AVR. SNES has fixed priority by default. Grant latches the address, avr_wr and avr_wdata.
- GRANT:
  - sram_addr valid; ce_n=0; strobes otherwise high.
  - For an AVR write, sram_dout_en=1 and sram_dout=avr_wdata.
- ACCESS:
  - Read: ce_n=0, oe_n=0 for RD_WAIT cycles.
  - Write: ce_n=0, we_n=0 for WR_WAIT cycles, with data driven.
  - sram_din is sampled on the last ACCESS clock edge into the granted requester's rdata register.
- RECOVER:
  - oe_n=we_n=1; ce_n=1.
  - For writes, sram_dout_en stays 1 this cycle (data hold), then drops in IDLE.
  - The granted requester's ack=1 for exactly this cycle.
- Latency, req sampled in IDLE at cycle 0:
  - Read ack in cycle RD_WAIT+2.
  - Write ack in cycle WR_WAIT+2.
  - Next grant earliest at cycle W+3.
- Requesters must deassert req the cycle after ack. If req is still high in IDLE, it is treated as a new request.
- Simultaneous snes_req and avr_req in IDLE: SNES wins. The AVR request stays pending and is served at the next IDLE with snes_req=0.
- A req that rises during GRANT/ACCESS/RECOVER is not accepted until IDLE. An in-flight access is never aborted.
- sram_dout_en and oe_n are never both active.
- A SNES write is impossible; snes_req is always a read.
- Reset mid-access: strobes return high immediately and asynchronously, bus is released, and no ack is issued.
- Address and data outputs change only in GRANT, so they are stable across the whole strobe window.

Optional Feature:
- Macro: SRAM_ARB_ROUND_ROBIN_EN.
- Defined:
  - After completing a SNES access with avr_req pending, the next IDLE arbitration grants AVR even if snes_req=1.
  - After an AVR grant, priority returns to SNES.
  - This bounds AVR wait to one SNES access.
- Undefined: fixed SNES priority; AVR may starve while snes_req is continuously asserted.

Test Plan:
- Reset, then AVR write avr_addr=0x012345, avr_wdata=0xA5 (WR_WAIT=2):
  - we_n low exactly 2 cycles; sram_addr=0x012345; sram_dout_en high GRANT..RECOVER.
  - avr_ack pulse at cycle 4.
- AVR read 0x012345 with sram_din model returning 0xA5 → avr_rdata=0xA5 with avr_ack at cycle 4; oe_n low 2 cycles; sram_dout_en=0 throughout.
- snes_req and avr_req rise in the same cycle (SNES 0x000010, AVR write 0x000020):
  - SNES served first, snes_ack at cycle 4.
  - AVR granted at cycle 5, avr_ack at cycle 9.
- snes_req held continuously with avr_req pending for 20 cycles:
  - With SRAM_ARB_ROUND_ROBIN_EN, grants alternate SNES/AVR.
  - Without it, avr_ack never asserts.
- reset_n pulsed low during ACCESS of a write → strobes high and sram_dout_en=0 in the same cycle, no ack, state IDLE after release.
- Back-to-back SNES reads 0x100/0x101 with sram_din 0x11/0x22 → snes_rdata 0x11 then 0x22; acks 5 cycles apart; ce_n high in each RECOVER.
